// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop rx synchroniser, mid-bit sampling and a one-entry AXI-stream holding register.
// Define UART_RX_PARITY_EN for 8E1 frames (even parity bit after the data) and the extra parity_error pulse output.
module uart_rx #(
   parameter int cycles_per_bit = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       tready,
   output logic       tvalid,
   output logic [7:0] tdata,
   output logic       overflow,
   output logic       framing_error
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_error
`endif
);

   localparam int CW = (cycles_per_bit > 1) ? $clog2(cycles_per_bit) : 1;
   localparam logic [CW-1:0] FULL_BIT = CW'(cycles_per_bit - 1);
   localparam logic [CW-1:0] HALF_BIT = CW'(cycles_per_bit / 2 - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } state_t;

   state_t         state, state_nxt;
   logic           rx_meta, rx_s;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [2:0]     bit_idx, bit_idx_nxt;
   logic [7:0]     shreg, shreg_nxt;
   logic           tvalid_nxt;
   logic [7:0]     tdata_nxt;
   logic           overflow_nxt, framing_error_nxt;
   logic           tick;
   logic           deliver;
   logic           par_ok;
`ifdef UART_RX_PARITY_EN
   logic           par_bit, par_bit_nxt;
   logic           parity_error_nxt;
`endif

   assign tick = (cnt == '0);

`ifdef UART_RX_PARITY_EN
   // Even parity: data bits plus parity bit must XOR to zero.
   assign par_ok = ~(^{shreg, par_bit});
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta       <= 1'b1;
         rx_s          <= 1'b1;
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         tvalid        <= 1'b0;
         tdata         <= '0;
         overflow      <= 1'b0;
         framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit       <= 1'b0;
         parity_error  <= 1'b0;
`endif
      end else begin
         rx_meta       <= rx;
         rx_s          <= rx_meta;
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         bit_idx       <= bit_idx_nxt;
         shreg         <= shreg_nxt;
         tvalid        <= tvalid_nxt;
         tdata         <= tdata_nxt;
         overflow      <= overflow_nxt;
         framing_error <= framing_error_nxt;
`ifdef UART_RX_PARITY_EN
         par_bit       <= par_bit_nxt;
         parity_error  <= parity_error_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt         = state;
      cnt_nxt           = cnt;
      bit_idx_nxt       = bit_idx;
      shreg_nxt         = shreg;
      tvalid_nxt        = tvalid;
      tdata_nxt         = tdata;
      overflow_nxt      = 1'b0;
      framing_error_nxt = 1'b0;
      deliver           = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_nxt       = par_bit;
      parity_error_nxt  = 1'b0;
`endif

      if (tvalid && tready)
         tvalid_nxt = 1'b0;

      if (state != IDLE && state != BREAK && !tick)
         cnt_nxt = cnt - 1'b1;

      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nxt = START;
               cnt_nxt   = HALF_BIT;
            end
         end
         START: begin
            // Re-check the line at mid start bit so short glitches are rejected.
            if (tick) begin
               if (!rx_s) begin
                  state_nxt   = DATA;
                  cnt_nxt     = FULL_BIT;
                  bit_idx_nxt = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shreg_nxt   = {rx_s, shreg[7:1]};
               cnt_nxt     = FULL_BIT;
               bit_idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               par_bit_nxt = rx_s;
               cnt_nxt     = FULL_BIT;
               state_nxt   = STOP;
            end
         end
`endif
         STOP: begin
            // Leave at mid stop bit so the next start edge is caught with half a bit of margin.
            if (tick) begin
`ifdef UART_RX_PARITY_EN
               parity_error_nxt = ~par_ok;
`endif
               if (rx_s) begin
                  deliver   = par_ok;
                  state_nxt = IDLE;
               end else begin
                  framing_error_nxt = 1'b1;
                  state_nxt         = BREAK;
               end
            end
         end
         BREAK: begin
            if (rx_s)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (deliver) begin
         if (!tvalid || tready) begin
            tdata_nxt  = shreg;
            tvalid_nxt = 1'b1;
         end else begin
            overflow_nxt = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected bytes queued at send time and
// compared against beats captured on the AXI-stream port; error pulses are counted and checked per step.
module tb_uart_rx;

   localparam int CPB = 434;
`ifdef UART_RX_PARITY_EN
   localparam int EXP_LAT = 4126 + CPB;
`else
   localparam int EXP_LAT = 4126;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       tready;
   logic       tvalid;
   logic [7:0] tdata;
   logic       overflow;
   logic       framing_error;
`ifdef UART_RX_PARITY_EN
   logic       parity_error;
`endif

   uart_rx #(.cycles_per_bit(CPB)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .tready(tready),
      .tvalid(tvalid),
      .tdata(tdata),
      .overflow(overflow),
      .framing_error(framing_error)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_error(parity_error)
`endif
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   always @(posedge clk) cyc++;

   // Output monitor, sampling on the falling edge.
   logic [7:0] got_q[$];
   int         ovf_cnt = 0, ferr_cnt = 0, perr_cnt = 0, unstable_cnt = 0, rise_cyc = 0;
   logic       prev_vld = 1'b0, prev_hold = 1'b0;
   logic [7:0] prev_dat = 8'h00;

   always @(negedge clk) begin
      if (!rst) begin
         if (tvalid && tready) got_q.push_back(tdata);
         if (overflow) ovf_cnt++;
         if (framing_error) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
         if (parity_error) perr_cnt++;
`endif
         if (tvalid && !prev_vld) rise_cyc = cyc;
         if (prev_hold && tdata !== prev_dat) unstable_cnt++;
         prev_hold = tvalid && !tready;
         prev_vld  = tvalid;
         prev_dat  = tdata;
      end else begin
         prev_hold = 1'b0;
         prev_vld  = 1'b0;
      end
   end

   int         vectors = 0, miscompares = 0;
   logic [7:0] exp_q[$];
   int         rd_idx = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic v);
      rx = v;
      wait_clk(CPB);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len,
                             input logic par_flip, input logic expect_it);
      if (expect_it) exp_q.push_back(b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^b) ^ par_flip);
`endif
      rx = stop_v;
      wait_clk(CPB * stop_len);
      rx = 1'b1;
   endtask

   task automatic drain(input string tag);
      int         n;
      int         t;
      logic [7:0] e;
      n = exp_q.size();
      t = 0;
      while ((got_q.size() - rd_idx) < n && t < 4 * CPB) begin
         wait_clk(1);
         t++;
      end
      check({tag, "_beats"}, got_q.size() - rd_idx, n);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd_idx < got_q.size()) begin
            check({tag, "_data"}, {24'h0, got_q[rd_idx]}, {24'h0, e});
            rd_idx++;
         end
      end
      rd_idx = got_q.size();
   endtask

   initial begin
      int ovf0, ferr0, perr0, sc, lat;
      rst    = 1'b1;
      rx     = 1'b1;
      tready = 1'b1;
      wait_clk(3);
      check("rst_tvalid", tvalid, 0);
      check("rst_tdata", tdata, 0);
      check("rst_overflow", overflow, 0);
      check("rst_framing_error", framing_error, 0);
      rst = 1'b0;
      wait_clk(10);

      // Single byte, latency from start edge to tvalid.
      ovf0 = ovf_cnt; ferr0 = ferr_cnt;
      sc = cyc;
      send_frame(8'hA5, 1'b1, 1, 1'b0, 1'b1);
      drain("a5");
      lat = rise_cyc - sc;
      check("a5_latency_in_window", (lat >= EXP_LAT - 4 && lat <= EXP_LAT + 4), 1);
      check("a5_tvalid_low_after", tvalid, 0);
      check("a5_no_error_pulses", (ovf_cnt - ovf0) + (ferr_cnt - ferr0), 0);

      // Seven back-to-back frames with no idle gap.
      ovf0 = ovf_cnt;
      for (int i = 0; i < 7; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1, 1'b0, 1'b1);
      drain("b2b");
      check("b2b_no_overflow", ovf_cnt - ovf0, 0);

      // Short low glitch on an idle line must be ignored.
      ferr0 = ferr_cnt;
      rx = 1'b0;
      wait_clk(100);
      rx = 1'b1;
      wait_clk(2 * CPB);
      drain("glitch");
      check("glitch_no_framing_error", ferr_cnt - ferr0, 0);
      send_frame(8'h3C, 1'b1, 1, 1'b0, 1'b1);
      drain("after_glitch");

      // Stop bit low for two bit times: one framing_error pulse, byte dropped.
      ferr0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, 2, 1'b0, 1'b0);
      wait_clk(CPB);
      check("ferr_single_pulse", ferr_cnt - ferr0, 1);
      drain("ferr");
      send_frame(8'h81, 1'b1, 1, 1'b0, 1'b1);
      drain("after_ferr");

      // Consumer stalled: first byte held, second dropped with overflow.
      tready = 1'b0;
      ovf0 = ovf_cnt; ferr0 = ferr_cnt;
      send_frame(8'h11, 1'b1, 1, 1'b0, 1'b1);
      send_frame(8'h22, 1'b1, 1, 1'b0, 1'b0);
      wait_clk(10);
      check("stall_tvalid_held", tvalid, 1);
      check("stall_tdata_held", tdata, 8'h11);
      check("stall_overflow_once", ovf_cnt - ovf0, 1);
      check("stall_tdata_stable", unstable_cnt, 0);
      check("stall_no_ferr", ferr_cnt - ferr0, 0);
      tready = 1'b1;
      drain("stall");
      wait_clk(2);
      check("stall_tvalid_drops", tvalid, 0);

      // Reset during bit 4 of 0xF0.
      ovf0 = ovf_cnt; ferr0 = ferr_cnt;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      rx = 1'b1;
      wait_clk(CPB / 2);
      rst = 1'b1;
      #1;
      check("midrst_tvalid", tvalid, 0);
      check("midrst_tdata", tdata, 0);
      check("midrst_overflow", overflow, 0);
      check("midrst_framing_error", framing_error, 0);
      wait_clk(5);
      rst = 1'b0;
      wait_clk(CPB * 6);
      check("midrst_no_pulses", (ovf_cnt - ovf0) + (ferr_cnt - ferr0), 0);
      drain("midrst");
      send_frame(8'h5A, 1'b1, 1, 1'b0, 1'b1);
      drain("after_rst");

`ifdef UART_RX_PARITY_EN
      // 0x07 has odd weight, so parity bit 0 is wrong.
      perr0 = perr_cnt;
      send_frame(8'h07, 1'b1, 1, 1'b1, 1'b0);
      wait_clk(10);
      check("parity_error_pulse", perr_cnt - perr0, 1);
      drain("parity");
`else
      perr0 = perr_cnt;
      check("no_parity_pulses", perr_cnt - perr0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver: the counterpart of uart_tx, on the far end of the wire.
- Oversamples the asynchronous rx line in the clk domain and recovers 8N1 frames (start, 8 data bits LSB first, stop).
- Presents each received byte on an AXI-stream master port with a one-entry output holding register.
- Feeds byte-oriented consumers, e.g. a FIFO or command parser.

Parameters:
cycles_per_bit, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 4.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
tready  input  1  AXI-stream ready from consumer
tvalid  output  1  AXI-stream valid; byte held in tdata
tdata  output  8  received byte, bit 0 = first data bit on wire
overflow  output  1  one-cycle pulse: byte dropped because holding register full
framing_error  output  1  one-cycle pulse: stop bit sampled low, byte discarded

Behaviour:
- Reset (async assert, release sync to clk): tvalid=0, tdata=0, overflow=0, framing_error=0, state=IDLE, synchronizer flops=1.
- rx passes a 2-flop synchronizer (rx_s) before any use; all sampling uses rx_s.
- Bit-timer down-counter, width $clog2(cycles_per_bit); "tick" = counter==0.
- IDLE: on rx_s==0 go START; counter = cycles_per_bit/2 - 1 (integer division).
- START: on tick, if rx_s==0 go DATA with counter=cycles_per_bit-1 and bit_idx=0; if rx_s==1 (glitch) return IDLE, no outputs.
- DATA: on tick, shift rx_s into shift register MSB, right-shifting (LSB first); reload counter; after bit_idx 7 go STOP.
- STOP: on tick (mid stop bit):
  - rx_s==1 -> deliver byte, go IDLE immediately (half-bit early, for back-to-back resync).
  - rx_s==0 -> framing_error pulse, byte discarded, go BREAK.
- BREAK: wait until rx_s==1, then IDLE; no start detection while in BREAK.
- Deliver rule, same cycle as the stop tick: if tvalid==0, or tvalid&&tready, load tdata and set tvalid=1 on next edge. Otherwise assert overflow for 1 cycle, keep the old tdata/tvalid, drop the new byte.
- tvalid falls on the edge after tvalid&&tready unless a new byte is loaded that same cycle.
- tdata is stable while tvalid=1 and tready=0.
- Latency: tvalid asserts 1 clk after the stop-bit mid-sample, plus the 2-cycle synchronizer delay from the wire.
- overflow and framing_error are never asserted simultaneously for the same frame.
- Reset mid-frame: partial byte discarded, no pulse outputs, return to IDLE.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP; one parity bit sampled at mid-bit.
  - Even parity over the 8 data bits.
  - Adds output parity_error (1-bit pulse). On mismatch, parity_error pulses on the stop tick and the byte is discarded; the stop bit is still checked.
  - Frame is 11 bits.
- Undefined: no PARITY state, no parity_error port, pure 8N1.

Test Plan:
- rx idle high, tready=1, send 0xA5 at 434 cycles/bit -> exactly one tvalid beat, tdata=0xA5, ~4125 cycles after start edge; no error pulses.
- 7 back-to-back random bytes, zero idle between frames, tready=1 -> 7 beats, same order and values, no overflow.
- 100-cycle low glitch on idle rx -> no tvalid, no framing_error; a following 0x3C frame is received correctly.
- Frame 0x3C with stop bit driven low, then rx high after 2 bit times -> framing_error single pulse, no tvalid; next frame 0x81 received.
- tready=0, send 0x11 then 0x22 -> tvalid=1 with tdata=0x11 throughout, overflow pulses once at 0x22 stop tick; raise tready -> one beat 0x11, then tvalid=0.
- Assert rst during bit 4 of 0xF0 -> outputs zero immediately; after release, frame 0x5A -> tdata=0x5A only. Under UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_error pulse, no tvalid.
